// File: rtl/spy_path_test_ctrl.sv
// spy_path_test_ctrl: launch/capture sequencer for one spy path.
// Counts capture mismatches per trigger pattern and streams results.
module spy_path_test_ctrl #(
    parameter int TRIALS   = 16,
    parameter int SETTLE   = 4,
    parameter int CNT_W    = 8,
    parameter int PATH_INV = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       cfg_pat_en,
    input  logic             path_out,
    output logic             path_launch,
    output logic             ht_in1,
    output logic             ht_in2,
    output logic             busy,
    output logic             done,
    output logic             res_valid,
    output logic [1:0]       res_pat,
    output logic [CNT_W-1:0] res_errs,
    input  logic             res_ready
);

    localparam int TW = $clog2(TRIALS + 1);
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] ERR_MAX = '1;
    localparam logic INV = (PATH_INV != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LAUNCH,
        S_WAIT,
        S_CAPTURE,
        S_REPORT,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [3:0]       mask_q;
    logic [1:0]       pat_q;
    logic [CNT_W-1:0] err_q;
    logic [TW-1:0]    trial_q;
    logic [CW-1:0]    cnt_q;
    logic             s1_q;
    logic             s2_q;
    logic             chk_q;
    logic             exp_q;
    logic             launch_q;
    logic             ht1_q;
    logic             ht2_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;

    logic [3:0]       hi_d;
    logic [1:0]       first_pat_d;
    logic [1:0]       next_pat_d;
    logic [TW-1:0]    trial_d;
    logic [CNT_W-1:0] err_d;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Pattern selection, trial count and the delayed mismatch check.
    // The check runs one cycle after CAPTURE so the synchronizer output
    // reflects a path that settled within SETTLE-2 cycles of launch.
    always_comb begin
        hi_d        = mask_q & (4'b1110 << pat_q);
        first_pat_d = lowest(mask_q);
        next_pat_d  = lowest(hi_d);
        trial_d     = trial_q + 1'b1;
        err_d       = err_q;
        if (chk_q && (s2_q != exp_q) && (err_q != ERR_MAX))
            err_d = err_q + 1'b1;
    end

    // Sequencer FSM with registered outputs and 2-flop synchronizer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            pat_q    <= '0;
            err_q    <= '0;
            trial_q  <= '0;
            cnt_q    <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            chk_q    <= 1'b0;
            exp_q    <= 1'b0;
            launch_q <= 1'b0;
            ht1_q    <= 1'b0;
            ht2_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            s1_q   <= path_out;
            s2_q   <= s1_q;
            chk_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= err_d;
            unique case (state_q)
                S_IDLE: begin
                    if (busy_q) begin
                        if (mask_q == 4'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_SETUP;
                            pat_q    <= first_pat_d;
                            ht1_q    <= first_pat_d[1];
                            ht2_q    <= first_pat_d[0];
                            launch_q <= 1'b0;
                            err_q    <= '0;
                            trial_q  <= '0;
                            cnt_q    <= '0;
                        end
                    end else if (start) begin
                        mask_q <= cfg_pat_en;
                        busy_q <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == CW'(SETTLE - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_LAUNCH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_LAUNCH: begin
                    launch_q <= ~launch_q;
                    cnt_q    <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == CW'(SETTLE - 2)) begin
                        cnt_q   <= '0;
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    chk_q   <= 1'b1;
                    exp_q   <= launch_q ^ INV;
                    trial_q <= trial_d;
                    if (trial_d == TW'(TRIALS))
                        state_q <= S_REPORT;
                    else
                        state_q <= S_LAUNCH;
                end
                S_REPORT: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (res_ready) begin
                        valid_q <= 1'b0;
                        if (hi_d != 4'd0) begin
                            state_q  <= S_SETUP;
                            pat_q    <= next_pat_d;
                            ht1_q    <= next_pat_d[1];
                            ht2_q    <= next_pat_d[0];
                            launch_q <= 1'b0;
                            err_q    <= '0;
                            trial_q  <= '0;
                            cnt_q    <= '0;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    busy_q   <= 1'b0;
                    ht1_q    <= 1'b0;
                    ht2_q    <= 1'b0;
                    launch_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign path_launch = launch_q;
    assign ht_in1      = ht1_q;
    assign ht_in2      = ht2_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign res_valid   = valid_q;
    assign res_pat     = pat_q;
    assign res_errs    = err_q;

endmodule

// File: tb/tb_spy_path_test_ctrl.sv
// Scoreboard bench for spy_path_test_ctrl: default instance A and a
// long-trial instance B for counter saturation.
module tb_spy_path_test_ctrl;

    typedef struct packed {
        logic [1:0] pat;
        logic [7:0] errs;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       start_a, pout_a, launch_a, ht1_a, ht2_a;
    logic       busy_a, done_a, rv_a, rr_a;
    logic [3:0] cfg_a;
    logic [1:0] rp_a;
    logic [7:0] re_a;

    logic       start_b, pout_b, launch_b, ht1_b, ht2_b;
    logic       busy_b, done_b, rv_b, rr_b;
    logic [3:0] cfg_b;
    logic [1:0] rp_b;
    logic [7:0] re_b;

    int total = 0;
    int bad = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    res_t qa[$];
    res_t qb[$];
    res_t ea, eb;

    // Path models: 0 = launch delayed dly clocks, 1 = stuck-at-0, 2 = inverted.
    int mode_a = 0;
    int dly_a = 1;
    int mode_b = 1;
    logic [2:0] sh_a = 3'b000;
    always @(posedge clk) sh_a <= {sh_a[1:0], launch_a};
    assign pout_a = (mode_a == 1) ? 1'b0 :
                    (mode_a == 2) ? ~launch_a : sh_a[dly_a-1];
    assign pout_b = (mode_b == 1) ? 1'b0 : ~launch_b;

    spy_path_test_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cfg_pat_en(cfg_a),
        .path_out(pout_a), .path_launch(launch_a), .ht_in1(ht1_a),
        .ht_in2(ht2_a), .busy(busy_a), .done(done_a), .res_valid(rv_a),
        .res_pat(rp_a), .res_errs(re_a), .res_ready(rr_a)
    );

    spy_path_test_ctrl #(.TRIALS(300)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cfg_pat_en(cfg_b),
        .path_out(pout_b), .path_launch(launch_b), .ht_in1(ht1_b),
        .ht_in2(ht2_b), .busy(busy_b), .done(done_b), .res_valid(rv_b),
        .res_pat(rp_b), .res_errs(re_b), .res_ready(rr_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops an expected result at every accepted handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_a) done_cnt_a++;
            if (done_b) done_cnt_b++;
            if (rv_a && rr_a) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_result", {22'd0, rp_a, re_a}, 32'hFFFF);
                end else begin
                    ea = qa.pop_front();
                    chk("a_result", {22'd0, rp_a, re_a}, {22'd0, ea});
                end
            end
            if (rv_b && rr_b) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_result", {22'd0, rp_b, re_b}, 32'hFFFF);
                end else begin
                    eb = qb.pop_front();
                    chk("b_result", {22'd0, rp_b, re_b}, {22'd0, eb});
                end
            end
        end
    end

    function automatic logic [31:0] outs_a();
        return {17'd0, launch_a, ht1_a, ht2_a, busy_a, done_a, rv_a, rp_a, re_a};
    endfunction

    task automatic start_run(input bit b, input logic [3:0] m);
        @(posedge clk);
        #1;
        if (b) begin cfg_b = m; start_b = 1'b1; end
        else   begin cfg_a = m; start_a = 1'b1; end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit b, input int budget, input string nm);
        int n = 0;
        @(negedge clk);
        while ((b ? done_b : done_a) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_seen"}, {31'd0, b ? done_b : done_a}, 32'd1);
        @(negedge clk);
        chk({nm, "_busy_low"}, {31'd0, b ? busy_b : busy_a}, 32'd0);
        chk({nm, "_done_low"}, {31'd0, b ? done_b : done_a}, 32'd0);
        chk({nm, "_q_empty"}, b ? qb.size() : qa.size(), 32'd0);
    endtask

    initial begin
        int n;
        int d0;
        rst_n = 1'b0;
        start_a = 1'b0; cfg_a = 4'd0; rr_a = 1'b1;
        start_b = 1'b0; cfg_b = 4'd0; rr_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_a", outs_a(), 32'd0);
        chk("reset_busy_b", {31'd0, busy_b | rv_b | done_b}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Ideal loopback, all four patterns.
        mode_a = 0; dly_a = 1;
        qa.push_back('{2'd0, 8'd0});
        qa.push_back('{2'd1, 8'd0});
        qa.push_back('{2'd2, 8'd0});
        qa.push_back('{2'd3, 8'd0});
        start_run(0, 4'b1111);
        wait_done(0, 600, "loopback");

        // Stuck-at-0 and inverted paths.
        mode_a = 1;
        qa.push_back('{2'd0, 8'd8});
        start_run(0, 4'b0001);
        wait_done(0, 200, "stuck0");
        mode_a = 2;
        qa.push_back('{2'd0, 8'd16});
        start_run(0, 4'b0001);
        wait_done(0, 200, "inverted");

        // Delay sweep.
        mode_a = 0; dly_a = 2;
        qa.push_back('{2'd1, 8'd0});
        start_run(0, 4'b0010);
        wait_done(0, 200, "delay2");
        dly_a = 3;
        qa.push_back('{2'd2, 8'd16});
        start_run(0, 4'b0100);
        wait_done(0, 200, "delay3");

        // Backpressure on the first of two patterns.
        mode_a = 1;
        rr_a = 1'b0;
        qa.push_back('{2'd0, 8'd8});
        qa.push_back('{2'd3, 8'd8});
        start_run(0, 4'b1001);
        n = 0;
        @(negedge clk);
        while (rv_a !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", {31'd0, rv_a}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold", {18'd0, rv_a, rp_a, re_a, ht1_a, ht2_a, launch_a, busy_a},
                {18'd0, 1'b1, 2'd0, 8'd8, 1'b0, 1'b0, 1'b0, 1'b1});
        end
        @(posedge clk);
        #1 rr_a = 1'b1;
        wait_done(0, 300, "backpressure");

        // Start and mask changes while busy are ignored.
        mode_a = 0; dly_a = 1;
        d0 = done_cnt_a;
        qa.push_back('{2'd0, 8'd0});
        start_run(0, 4'b0001);
        repeat (10) @(posedge clk);
        start_run(0, 4'b1111);
        wait_done(0, 200, "start_busy");
        repeat (150) @(negedge clk);
        chk("start_busy_done_count", done_cnt_a - d0, 32'd1);
        chk("start_busy_idle", {31'd0, busy_a}, 32'd0);

        // Empty mask: done two cycles after start, no result.
        @(posedge clk);
        #1 cfg_a = 4'd0; start_a = 1'b1;
        @(negedge clk);
        chk("mask0_c0", {30'd0, busy_a, done_a}, 32'd0);
        @(posedge clk);
        #1 start_a = 1'b0;
        @(negedge clk);
        chk("mask0_c1", {30'd0, busy_a, done_a}, 32'd2);
        @(negedge clk);
        chk("mask0_c2", {30'd0, busy_a, done_a}, 32'd3);
        @(negedge clk);
        chk("mask0_c3", {30'd0, busy_a, done_a}, 32'd0);

        // Reset during WAIT of pattern 2.
        d0 = done_cnt_a;
        start_run(0, 4'b0100);
        n = 0;
        @(negedge clk);
        while (launch_a !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wait_reached", {30'd0, ht1_a, ht2_a}, 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", outs_a(), 32'd0);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);
        chk("rst_no_done", done_cnt_a - d0, 32'd0);
        chk("rst_stays_idle", outs_a(), 32'd0);

        // Long runs on instance B: 150 and saturation at 255.
        mode_b = 1;
        qb.push_back('{2'd0, 8'd150});
        start_run(1, 4'b0001);
        wait_done(1, 3000, "b_stuck0");
        mode_b = 2;
        qb.push_back('{2'd2, 8'd255});
        start_run(1, 4'b0100);
        wait_done(1, 3000, "b_saturate");
        chk("b_done_count", done_cnt_b, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
